// File: rtl/dot_product_seq_ctrl_if.sv
// dot_product_seq_ctrl_if: load, operand, datapath and result signals of the dot-product sequencer
interface dot_product_seq_ctrl_if #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int A = 10,
  parameter int S = 48
);
  logic             i_ld_valid;
  logic [A-1:0]     i_ld_addr;
  logic [M*N-1:0]   i_ld_data;
  logic             o_ld_ready;
  logic             i_start;
  logic [A-1:0]     i_base;
  logic [A-1:0]     i_len;
  logic             i_a_valid;
  logic [M*N-1:0]   i_a;
  logic             o_a_ready;
  logic [M*N-1:0]   o_dp_b;
  logic [A-1:0]     o_dp_b_addr;
  logic             o_dp_wren;
  logic [M*N-1:0]   o_dp_a;
  logic             o_dp_first;
  logic             o_dp_last;
  logic [S-1:0]     i_dp_sum;
  logic             i_dp_valid;
  logic [S-1:0]     o_sum;
  logic             o_sum_valid;
  logic             o_busy;
  logic             o_err;
  modport master (
    output i_ld_valid, i_ld_addr, i_ld_data, i_start, i_base, i_len, i_a_valid, i_a, i_dp_sum, i_dp_valid,
    input  o_ld_ready, o_a_ready, o_dp_b, o_dp_b_addr, o_dp_wren, o_dp_a, o_dp_first, o_dp_last,
           o_sum, o_sum_valid, o_busy, o_err
  );
  modport slave (
    input  i_ld_valid, i_ld_addr, i_ld_data, i_start, i_base, i_len, i_a_valid, i_a, i_dp_sum, i_dp_valid,
    output o_ld_ready, o_a_ready, o_dp_b, o_dp_b_addr, o_dp_wren, o_dp_a, o_dp_first, o_dp_last,
           o_sum, o_sum_valid, o_busy, o_err
  );
endinterface

// File: rtl/dot_product_seq_ctrl.sv
// dot_product_seq_ctrl: loads B into BRAM, streams A items with B addresses to the datapath, captures the result
module dot_product_seq_ctrl #(
  parameter int N   = 8,
  parameter int M   = 8,
  parameter int A   = 10,
  parameter int S   = 48,
  parameter int TMO = 64
) (
  input logic                 i_clk,
  input logic                 i_reset,
  dot_product_seq_ctrl_if.slave bus
);
  localparam int W  = M * N;
  localparam int TW = $clog2(TMO + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state_q;
  logic [W-1:0]  dp_b_q, dp_a_q;
  logic [A-1:0]  dp_b_addr_q, base_q, len_q, k_q;
  logic          dp_wren_q, dp_first_q, dp_last_q, sum_valid_q, err_q;
  logic [S-1:0]  sum_q;
  logic [TW-1:0] tmo_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      dp_b_q      <= '0;
      dp_a_q      <= '0;
      dp_b_addr_q <= '0;
      base_q      <= '0;
      len_q       <= '0;
      k_q         <= '0;
      dp_wren_q   <= 1'b0;
      dp_first_q  <= 1'b0;
      dp_last_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
      sum_q       <= '0;
      tmo_q       <= '0;
    end else begin
      dp_wren_q   <= 1'b0;
      dp_first_q  <= 1'b0;
      dp_last_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_ld_valid) begin
            dp_wren_q   <= 1'b1;
            dp_b_q      <= bus.i_ld_data;
            dp_b_addr_q <= bus.i_ld_addr;
          end
          if (bus.i_start) begin
            base_q  <= bus.i_base;
            len_q   <= bus.i_len;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: if (bus.i_a_valid) begin
          dp_a_q      <= bus.i_a;
          dp_b_addr_q <= base_q + k_q;
          dp_first_q  <= k_q == '0;
          dp_last_q   <= k_q == len_q;
          k_q         <= k_q + 1'b1;
          if (k_q == len_q) begin
            state_q <= DRAIN;
            tmo_q   <= '0;
          end
        end
        DRAIN: if (bus.i_dp_valid) begin
          sum_q       <= bus.i_dp_sum;
          sum_valid_q <= 1'b1;
          state_q     <= IDLE;
        end else if (tmo_q == TW'(TMO - 1)) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.o_ld_ready  = state_q == IDLE;
  assign bus.o_a_ready   = state_q == RUN;
  assign bus.o_busy      = state_q != IDLE;
  assign bus.o_dp_b      = dp_b_q;
  assign bus.o_dp_b_addr = dp_b_addr_q;
  assign bus.o_dp_wren   = dp_wren_q;
  assign bus.o_dp_a      = dp_a_q;
  assign bus.o_dp_first  = dp_first_q;
  assign bus.o_dp_last   = dp_last_q;
  assign bus.o_sum       = sum_q;
  assign bus.o_sum_valid = sum_valid_q;
  assign bus.o_err       = err_q;
endmodule

// File: doc/dot_product_seq_ctrl.md
DOT_PRODUCT_SEQ_CTRL -- requirements
Module: dot_product_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning integer width of each vector element.
REQ-002 The block SHALL have parameter M, default 8, meaning elements per vector item.
REQ-003 The block SHALL have parameter A, default 10, meaning BRAM address width.
REQ-004 The block SHALL have parameter S, default 48, meaning result width.
REQ-005 The block SHALL have parameter TMO, default 64, meaning the drain timeout in cycles (at least 1).
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 The block SHALL have these ports:
  i_clk  in  1  clock; all logic on rising edge
  i_reset  in  1  synchronous active-high reset
  i_ld_valid  in  1  BRAM load request
  i_ld_addr  in  A  BRAM load address
  i_ld_data  in  M*N  BRAM load data (B vector)
  o_ld_ready  out  1  load accepted (IDLE only)
  i_start  in  1  start one dot product
  i_base  in  A  BRAM start address of B operand
  i_len  in  A  item count minus 1 (0 means 1 item, max 2^A items)
  i_a_valid  in  1  A item available
  i_a  in  M*N  A item
  o_a_ready  out  1  A item accepted
  o_dp_b  out  M*N  datapath BRAM write data
  o_dp_b_addr  out  A  datapath BRAM address (write or read)
  o_dp_wren  out  1  datapath BRAM write enable
  o_dp_a  out  M*N  datapath A input
  o_dp_first  out  1  datapath first-item flag
  o_dp_last  out  1  datapath last-item flag
  i_dp_sum  in  S  datapath result
  i_dp_valid  in  1  datapath result valid
  o_sum  out  S  captured dot product
  o_sum_valid  out  1  one-cycle result strobe
  o_busy  out  1  state is not IDLE
  o_err  out  1  one-cycle timeout strobe

Function
REQ-008 The block SHALL implement three states: IDLE, RUN, DRAIN.
REQ-009 In IDLE, o_ld_ready SHALL be 1; a load handshake SHALL register o_dp_wren=1, o_dp_b=i_ld_data and o_dp_b_addr=i_ld_addr on the next cycle, otherwise o_dp_wren=0.
REQ-010 In IDLE, i_start=1 SHALL latch i_base and i_len, clear the item counter k, and enter RUN next cycle.
REQ-011 When i_start and i_ld_valid are both high in IDLE, the load SHALL complete that cycle and the start SHALL also be taken.
REQ-012 i_start SHALL be ignored outside IDLE.
REQ-013 In RUN, o_a_ready SHALL be 1 and o_ld_ready SHALL be 0; in IDLE and DRAIN, o_a_ready SHALL be 0.
REQ-014 Each RUN handshake (i_a_valid and o_a_ready) SHALL register the following on the next cycle; k SHALL then increment:
  o_dp_a = i_a
  o_dp_b_addr = (base+k) mod 2^A (address wraps)
  o_dp_first = (k==0)
  o_dp_last = (k==len)
  o_dp_wren = 0
REQ-015 Cycles without a handshake in RUN SHALL drive o_dp_first=0 and o_dp_last=0 and hold o_dp_a and o_dp_b_addr; gaps are permitted.
REQ-016 The handshake with k==len SHALL move the state to DRAIN and clear the timeout counter.
REQ-017 When len=0, the single item SHALL have first=1 and last=1 in the same cycle.
REQ-018 In DRAIN, i_dp_valid=1 SHALL register o_sum=i_dp_sum, pulse o_sum_valid for exactly 1 cycle, and return to IDLE.
REQ-019 In DRAIN, if TMO cycles elapse without i_dp_valid, the block SHALL pulse o_err for 1 cycle, leave o_sum unchanged, and return to IDLE.
REQ-020 i_dp_valid SHALL be ignored in IDLE and RUN.
REQ-021 o_busy SHALL be combinational from state (RUN or DRAIN).
REQ-022 Datapath-side and result outputs SHALL be registered.

Reset
REQ-023 On i_reset=1 the state SHALL become IDLE and every output SHALL be 0 on the next edge, except o_ld_ready=1 and o_busy=0, both derived from IDLE.
REQ-024 Reset mid-RUN or mid-DRAIN SHALL abort the operation with no o_sum_valid and no o_err.
REQ-025 A late i_dp_valid after reset SHALL be ignored.

Verification
REQ-026 Load addr 5, data 0x0102030405060708 -> next cycle: o_dp_wren=1, o_dp_b_addr=5, o_dp_b=0x0102030405060708; following cycle: o_dp_wren=0.
REQ-027 Start base=3, len=3, A valid every cycle -> o_dp_b_addr 3,4,5,6 on consecutive cycles; first on addr 3 only; last on addr 6 only; o_a_ready drops after 4 accepts.
REQ-028 Start base=1022, len=3, i_a_valid toggling 1/0 -> addresses 1022,1023,0,1 issued only on accepted items; flags zero in gap cycles.
REQ-029 Start len=0, then i_dp_valid with sum=0x000000000123 after 5 cycles -> o_sum=0x123 and o_sum_valid high for exactly 1 cycle; o_busy=0 next cycle; i_start while busy ignored.
REQ-030 DRAIN with no i_dp_valid -> o_err pulses 1 cycle after TMO=64 cycles; state returns to IDLE; o_sum unchanged.
REQ-031 Reset asserted at k=2 of a len=5 run -> all outputs 0 except o_ld_ready=1; a subsequent i_dp_valid produces no o_sum_valid.
